// File: rtl/lsu_pkg.sv
// Shared size encodings, FSM state enum and alignment helper for the load/store unit.
// LSU_MISALIGN_TRAP_EN adds the FAULT state used for misaligned-access traps.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

`ifdef LSU_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, FAULT} lsu_state_e;
`else
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE} lsu_state_e;
`endif

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      SZ_WORD: return lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane extraction with zero/sign extension for loads, and
// byte/halfword merge of store data into a read word for read-modify-write.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       size_i,
  input  logic             uns_i,
  input  logic [1:0]       lane_i,
  input  logic [WIDTH-1:0] rdata_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] ldata_o,
  output logic [WIDTH-1:0] mdata_o
);

  logic [4:0]       shamt;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] mask;

  // Addresses are already aligned to the size, so one byte-granular shift serves all sizes.
  assign shamt = {lane_i, 3'b000};
  assign sh    = rdata_i >> shamt;

  always_comb begin
    ldata_o = sh;
    mask    = '1;
    case (size_i)
      SZ_BYTE: begin
        ldata_o = uns_i ? WIDTH'(sh[7:0]) : {{(WIDTH-8){sh[7]}}, sh[7:0]};
        mask    = WIDTH'(8'hFF) << shamt;
      end
      SZ_HALF: begin
        ldata_o = uns_i ? WIDTH'(sh[15:0]) : {{(WIDTH-16){sh[15]}}, sh[15:0]};
        mask    = WIDTH'(16'hFFFF) << shamt;
      end
      default: ;
    endcase
  end

  assign mdata_o = (rdata_i & ~mask) | ((wdata_i << shamt) & mask);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit bridging core requests to a single-port word BRAM with 1-cycle read latency.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses; otherwise they are force-aligned.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_misaligned,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rdata
);

  lsu_state_e       state_q, state_d;
  logic             we_q, uns_q;
  logic [1:0]       size_q;
  logic [WIDTH-1:0] addr_q, word_q, word_d;
  logic [1:0]       size_eff;
  logic [WIDTH-1:0] addr_eff, ld_data, st_word;
  logic             accept, load_done;

  assign accept = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  assign size_eff = req_size;
  assign addr_eff = req_addr;
`else
  always_comb begin
    size_eff = (req_size == SZ_ILL) ? SZ_WORD : req_size;
    addr_eff = req_addr;
    case (size_eff)
      SZ_HALF: addr_eff[0]   = 1'b0;
      SZ_WORD: addr_eff[1:0] = 2'b00;
      default: ;
    endcase
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      addr_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      if (accept) begin
        we_q   <= req_we;
        uns_q  <= req_unsigned;
        size_q <= size_eff;
        addr_q <= addr_eff;
      end
    end
  end

  // word_q carries the store data until CAPTURE, then the merged word for WRITE.
  always_comb begin
    word_d = word_q;
    if (accept)
      word_d = req_wdata;
    else if (state_q == CAPTURE && we_q)
      word_d = st_word;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
          if (misaligned(req_size, req_addr[1:0]))
            state_d = FAULT;
          else
`endif
          if (req_we && size_eff == SZ_WORD)
            state_d = WRITE;
          else
            state_d = READ;
        end
      end
      READ:    state_d = CAPTURE;
      CAPTURE: state_d = we_q ? WRITE : IDLE;
      WRITE:   state_d = IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
      FAULT:   state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  lsu_align #(.WIDTH(WIDTH)) u_align (
    .size_i  (size_q),
    .uns_i   (uns_q),
    .lane_i  (addr_q[1:0]),
    .rdata_i (mem_rdata),
    .wdata_i (word_q),
    .ldata_o (ld_data),
    .mdata_o (st_word)
  );

  assign load_done  = (state_q == CAPTURE) && !we_q;
  assign req_ready  = (state_q == IDLE);
  assign mem_we     = (state_q == WRITE);
  assign mem_addr   = addr_q >> 2;
  assign mem_wdata  = word_q;
  assign resp_rdata = load_done ? ld_data : '0;

`ifdef LSU_MISALIGN_TRAP_EN
  assign resp_valid      = load_done || (state_q == WRITE) || (state_q == FAULT);
  assign resp_misaligned = (state_q == FAULT);
`else
  assign resp_valid      = load_done || (state_q == WRITE);
  assign resp_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-array reference model and a 16-word BRAM.
module tb_load_store_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]   req_size;
  logic [W-1:0] req_addr, req_wdata;
  logic         resp_valid, resp_misaligned, mem_we;
  logic [W-1:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0]  bram   [16];
  logic [31:0]  init_w [16];
  logic         preload;
  logic [7:0]   ref_b  [64];
  int           n_tests = 0;
  int           n_fail  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.WIDTH(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_we          (mem_we),
    .mem_rdata       (mem_rdata)
  );

  always @(posedge clk) begin
    if (preload) for (int i = 0; i < 16; i++) bram[i] <= init_w[i];
    else if (mem_we) bram[mem_addr[3:0]] <= mem_wdata;
    mem_rdata <= bram[mem_addr[3:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: byte-addressed memory, sizes as byte counts, latency from the access kind.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output logic [31:0] rdata, output logic mis,
                       output logic [31:0] wword, output logic [31:0] widx);
    int nb, a, wi;
    a = int'(addr[5:0]);
    rdata = 0; wword = 0; widx = 0; mis = 0; lat = 0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (size == 2'd3 || (size == 2'd1 && a % 2 != 0) || (size == 2'd2 && a % 4 != 0)) begin
      lat = 1; mis = 1;
      return;
    end
`endif
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    a  = a - a % nb;
    if (!we) begin
      for (int i = 0; i < nb; i++) rdata = rdata | (32'(ref_b[a+i]) << (8*i));
      if (!uns && nb < 4 && rdata[8*nb-1]) rdata = rdata | ~((32'd1 << (8*nb)) - 32'd1);
      lat = 2;
    end else begin
      for (int i = 0; i < nb; i++) ref_b[a+i] = wdata[8*i +: 8];
      wi    = a / 4;
      widx  = 32'(wi);
      wword = {ref_b[wi*4+3], ref_b[wi*4+2], ref_b[wi*4+1], ref_b[wi*4]};
      lat   = (nb == 4) ? 1 : 3;
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] g_rdata, output int g_lat, output logic g_mis,
                        output logic [31:0] g_waddr, output logic [31:0] g_wdata);
    int          e_lat, we_cnt;
    logic [31:0] e_rd, e_ww, e_wi;
    logic        e_mis;
    model(we, size, uns, addr, wdata, e_lat, e_rd, e_mis, e_ww, e_wi);
    @(negedge clk);
    chk("ready_before", req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    g_lat = 0; we_cnt = 0; g_rdata = 0; g_mis = 0; g_waddr = 0; g_wdata = 0;
    for (int n = 1; n <= 8 && g_lat == 0; n++) begin
      if (n > 1) @(negedge clk);
      if (mem_we) begin we_cnt++; g_waddr = mem_addr; g_wdata = mem_wdata; end
      if (resp_valid) begin g_lat = n; g_rdata = resp_rdata; g_mis = resp_misaligned; end
    end
    chk("latency", g_lat, e_lat);
    chk("rdata", g_rdata, e_rd);
    chk("misaligned", g_mis, e_mis);
    chk("mem_we_count", we_cnt, (we && !e_mis) ? 1 : 0);
    if (we && !e_mis) begin
      chk("mem_addr", g_waddr, e_wi);
      chk("mem_wdata", g_wdata, e_ww);
    end
    @(negedge clk);
    chk("idle_after_resp", {resp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    logic [31:0] rd, wa, wd, exp_q[$];
    int          lat, resps, issued, e_lat;
    logic        mis, seen, e_mis;
    logic [31:0] e_rd, e_ww, e_wi;

    for (int i = 0; i < 16; i++) init_w[i] = $urandom;
    init_w[1] = 32'h8899AABB;
    for (int i = 0; i < 64; i++) ref_b[i] = init_w[i/4][8*(i%4) +: 8];

    rst = 1'b1; preload = 1'b1;
    req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    #1;
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_resp", {resp_valid, resp_misaligned, mem_we}, 3'b000);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0; preload = 1'b0;

    do_req(1'b0, 2'd0, 1'b0, 32'h7, 32'h0, rd, lat, mis, wa, wd);
    chk("lb_s_0x7", rd, 32'hFFFFFF88);
    do_req(1'b0, 2'd1, 1'b1, 32'h4, 32'h0, rd, lat, mis, wa, wd);
    chk("lhu_0x4", rd, 32'h0000AABB);
    do_req(1'b1, 2'd0, 1'b0, 32'h5, 32'hCC, rd, lat, mis, wa, wd);
    chk("sb_lat", lat, 3);
    chk("sb_addr", wa, 32'h1);
    chk("sb_wdata", wd, 32'h8899CCBB);
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, rd, lat, mis, wa, wd);
    chk("lw_0x4", rd, 32'h8899CCBB);
    do_req(1'b0, 2'd2, 1'b0, 32'h6, 32'h0, rd, lat, mis, wa, wd);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_0x6_lat", lat, 1);
    chk("lw_0x6_mis", mis, 1'b1);
`else
    chk("lw_0x6_forced", rd, 32'h8899CCBB);
`endif

    repeat (150)
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 63)), $urandom, rd, lat, mis, wa, wd);

    // Reset in the WRITE cycle of a sub-word store: no write, no response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h9; req_wdata = 32'h5A;
    @(negedge clk);
    req_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 8 && !seen; n++) begin
      if (n > 0) @(negedge clk);
      if (mem_we) seen = 1'b1;
    end
    chk("rst_wr_reached", seen, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_wr_we_drop", mem_we, 1'b0);
    chk("rst_wr_no_resp", resp_valid, 1'b0);
    chk("rst_wr_idle", req_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, rd, lat, mis, wa, wd);

    // req_valid held high across three loads.
    resps = 0; issued = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        resps++;
        if (exp_q.size() > 0) chk("b2b_rdata", resp_rdata, exp_q.pop_front());
      end
      if (req_ready) begin
        if (issued < 3) begin
          req_we = 1'b0; req_size = 2'($urandom_range(0, 2));
          req_unsigned = 1'($urandom_range(0, 1)); req_addr = 32'($urandom_range(0, 63));
          model(1'b0, req_size, req_unsigned, req_addr, 32'h0, e_lat, e_rd, e_mis, e_ww, e_wi);
          exp_q.push_back(e_rd);
          req_valid = 1'b1;
          issued++;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    chk("b2b_resp_count", resps, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
